// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared widths and request type for the barrel shifter stream path
//
// Purpose: constants and the packed FIFO entry type used by barrel_shifter and
//          barrel_stream_ctrl.
// Contents:
//   BW_DATA     - shifter data width (8)
//   BW_SHAMT    - shift-amount width, log2(BW_DATA) (3)
//   shift_req_t - one buffered request {data, shamt}
package barrel_pkg;

   localparam int BW_DATA  = 8;
   localparam int BW_SHAMT = 3;

   typedef struct packed {
      logic [BW_DATA-1:0]  data;
      logic [BW_SHAMT-1:0] shamt;
   } shift_req_t;

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - combinational logical left barrel shifter, zero fill
//
// Purpose: result = (data << shamt) truncated to BW_DATA bits.
// Ports:
//   data   in  BW_DATA   value to shift
//   shamt  in  BW_SHAMT  shift amount, 0..BW_DATA-1
//   result out BW_DATA   shifted value
module barrel_shifter
   import barrel_pkg::*;
(
   input  logic [BW_DATA-1:0]  data,
   input  logic [BW_SHAMT-1:0] shamt,
   output logic [BW_DATA-1:0]  result
);

   logic [BW_DATA-1:0] acc;

   // Log-depth structure: stage i shifts by 2**i when shamt bit i is set.
   always_comb begin
      acc = data;
      for (int i = 0; i < BW_SHAMT; i++) begin
         if (shamt[i]) begin
            acc = acc << (1 << i);
         end
      end
      result = acc;
   end

endmodule

// File: rtl/barrel_stream_ctrl.sv
// rtl/barrel_stream_ctrl.sv - buffered valid/ready stream wrapper around barrel_shifter
//
// Purpose: accepts (data, shamt) pairs into a DEPTH-entry register FIFO, shifts
//          the FIFO head and presents each result from a registered output stage.
// Ports:
//   clk        in  1     rising-edge clock
//   reset      in  1     synchronous, active-high reset
//   in_valid   in  1     input pair valid
//   in_ready   out 1     pair can be accepted this cycle
//   in_data    in  DW    byte to shift
//   in_shamt   in  SW    shift amount
//   out_valid  out 1     out_data holds a result
//   out_ready  in  1     consumer accepts the result
//   out_data   out DW    shifted result
//   fifo_count out SW    entries held in the FIFO, 0..DEPTH
//   xfer_cnt   out 16    completed output transfers, wrapping
module barrel_stream_ctrl
   import barrel_pkg::*;
#(
   parameter int DW    = BW_DATA,
   parameter int SW    = BW_SHAMT,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [SW-1:0] in_shamt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [SW-1:0] fifo_count,
   output logic [15:0]   xfer_cnt
);

   localparam int PW = $clog2(DEPTH);

   shift_req_t        mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   shift_req_t        head;
   logic [DW-1:0]     shifted;
   logic              push;
   logic              load;
   logic              take;

   // in_ready depends only on registered occupancy, so a pop in the same cycle
   // never opens a slot for a full FIFO.
   assign in_ready = (fifo_count != SW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign take     = out_valid && out_ready;
   assign load     = (!out_valid || out_ready) && (fifo_count != '0);

   assign head = mem[rd_ptr];

   barrel_shifter u_shifter (
      .data   (head.data),
      .shamt  (head.shamt),
      .result (shifted)
   );

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[wr_ptr] <= '{data: in_data, shamt: in_shamt};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         xfer_cnt   <= '0;
      end else begin
         // Pointers wrap naturally since DEPTH is a power of two.
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (load) begin
            rd_ptr <= rd_ptr + PW'(1);
         end

         case ({push, load})
            2'b10:   fifo_count <= fifo_count + SW'(1);
            2'b01:   fifo_count <= fifo_count - SW'(1);
            default: fifo_count <= fifo_count;
         endcase

         // A load refills the output register in the same edge it drains;
         // otherwise a consumed result leaves out_data holding its last value.
         if (load) begin
            out_data  <= shifted;
            out_valid <= 1'b1;
         end else if (take) begin
            out_valid <= 1'b0;
         end

         if (take) begin
            xfer_cnt <= xfer_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_barrel_stream_ctrl.sv
// tb/tb_barrel_stream_ctrl.sv - directed self-checking bench for barrel_stream_ctrl
module tb_barrel_stream_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [2:0]  in_shamt;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [2:0]  fifo_count;
   logic [15:0] xfer_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   barrel_stream_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_shamt   (in_shamt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .fifo_count (fifo_count),
      .xfer_cnt   (xfer_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s);
      logic [15:0] w;
      w = {8'h00, d} << s;
      return w[7:0];
   endfunction

   logic [7:0] fill_exp [6];
   logic [7:0] expq [$];

   initial begin
      int acc_n;
      int nout;
      int npush;
      int cyc;
      logic acc;
      logic [7:0] rd [20];
      logic [2:0] rs [20];

      fill_exp = '{8'h22, 8'h88, 8'h98, 8'h40, 8'hA0, 8'h80};

      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; out_ready = 1'b0;
      @(negedge clk);
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_xfer_cnt", xfer_cnt, 0);
      check("rst_out_data", out_data, 0);
      reset = 1'b0;
      tick();
      check("in_ready_after_rst", in_ready, 1);

      // Single transfer: 81 << 1 = 02
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h81; in_shamt = 3'd1;
      tick();
      in_valid = 1'b0;
      check("single_not_yet_valid", out_valid, 0);
      check("single_count1", fifo_count, 1);
      tick();
      check("single_valid", out_valid, 1);
      check("single_data", out_data, 8'h02);
      tick();
      check("single_xfer", xfer_cnt, 1);
      check("single_drop", out_valid, 0);

      // Boundary shifts back to back
      in_valid = 1'b1; in_data = 8'hFF; in_shamt = 3'd7;
      tick();
      in_data = 8'h5A; in_shamt = 3'd0;
      tick();
      check("bnd_v0", out_valid, 1);
      check("bnd_d0", out_data, 8'h80);
      in_data = 8'h01; in_shamt = 3'd7;
      tick();
      in_valid = 1'b0;
      check("bnd_v1", out_valid, 1);
      check("bnd_d1", out_data, 8'h5A);
      tick();
      check("bnd_v2", out_valid, 1);
      check("bnd_d2", out_data, 8'h80);
      tick();
      check("bnd_drop", out_valid, 0);
      check("bnd_xfer", xfer_cnt, 4);

      // Back-pressure fill with distinct bytes 11/1, 22/2, 33/3, ...
      out_ready = 1'b0;
      acc_n = 0;
      in_valid = 1'b1; in_data = 8'h11; in_shamt = 3'd1;
      for (int c = 0; c < 9; c++) begin
         acc = in_ready;
         tick();
         if (acc) begin
            acc_n++;
            in_data = 8'h11 * 8'(acc_n + 1);
            in_shamt = 3'(acc_n + 1);
         end
         if (c >= 1) check("fill_hold", out_data, 8'h22);
      end
      check("fill_accepted", acc_n, 5);
      check("fill_in_ready", in_ready, 0);
      check("fill_count", fifo_count, 4);
      check("fill_valid", out_valid, 1);

      // Full with a one-cycle pop: pending pair 66/6 must not enter that cycle
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("fullpop_count", fifo_count, 3);
      check("fullpop_in_ready", in_ready, 1);
      check("fullpop_data", out_data, 8'h88);
      check("fullpop_xfer", xfer_cnt, 5);
      tick();
      in_valid = 1'b0;
      check("refill_count", fifo_count, 4);

      // Drain in push order, consecutive cycles
      out_ready = 1'b1;
      for (int j = 1; j < 6; j++) begin
         check("drain_valid", out_valid, 1);
         check("drain_data", out_data, fill_exp[j]);
         tick();
      end
      check("drain_drop", out_valid, 0);
      check("drain_count", fifo_count, 0);
      check("drain_xfer", xfer_cnt, 10);

      // Reset mid-stream with 3 buffered and a held result
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         in_data = 8'(k); in_shamt = 3'd0;
         tick();
      end
      in_valid = 1'b0;
      check("pre_rst_count", fifo_count, 3);
      check("pre_rst_valid", out_valid, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_valid", out_valid, 0);
      check("midrst_count", fifo_count, 0);
      check("midrst_xfer", xfer_cnt, 0);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("midrst_no_stale", out_valid, 0);
      end

      // 20 random pairs with random back-pressure against a queue scoreboard
      for (int k = 0; k < 20; k++) begin
         rd[k] = 8'($urandom);
         rs[k] = 3'($urandom);
      end
      rs[0] = 3'd7; rs[1] = 3'd0;
      npush = 0; nout = 0; cyc = 0;
      while ((nout < 20) && (cyc < 1000)) begin
         if (npush < 20) begin
            in_valid = 1'b1; in_data = rd[npush]; in_shamt = rs[npush];
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               check("rnd_unexpected_out", 1, 0);
            end else begin
               check("rnd_data", out_data, expq.pop_front());
            end
            nout++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(ref_shift(rd[npush], rs[npush]));
            npush++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check("rnd_outputs", nout, 20);
      check("rnd_xfer", xfer_cnt, 20);
      tick();
      check("rnd_empty", fifo_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
